// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Segment vectors are active-low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

    localparam int          DIGIT_W    = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;

    // Hex glyphs, active-low
    localparam logic [6:0]  GLYPH_0 = 7'h40;
    localparam logic [6:0]  GLYPH_1 = 7'h79;
    localparam logic [6:0]  GLYPH_2 = 7'h24;
    localparam logic [6:0]  GLYPH_3 = 7'h30;
    localparam logic [6:0]  GLYPH_4 = 7'h19;
    localparam logic [6:0]  GLYPH_5 = 7'h12;
    localparam logic [6:0]  GLYPH_6 = 7'h02;
    localparam logic [6:0]  GLYPH_7 = 7'h78;
    localparam logic [6:0]  GLYPH_8 = 7'h00;
    localparam logic [6:0]  GLYPH_9 = 7'h10;
    localparam logic [6:0]  GLYPH_A = 7'h08;
    localparam logic [6:0]  GLYPH_B = 7'h03;
    localparam logic [6:0]  GLYPH_C = 7'h46;
    localparam logic [6:0]  GLYPH_D = 7'h21;
    localparam logic [6:0]  GLYPH_E = 7'h06;

    typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-7-segment decode; the blank code turns every segment off.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    output logic [6:0]         seg
);

    // glyph lookup, anything outside 0..E is dark
    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'h0:    seg = GLYPH_0;
            4'h1:    seg = GLYPH_1;
            4'h2:    seg = GLYPH_2;
            4'h3:    seg = GLYPH_3;
            4'h4:    seg = GLYPH_4;
            4'h5:    seg = GLYPH_5;
            4'h6:    seg = GLYPH_6;
            4'h7:    seg = GLYPH_7;
            4'h8:    seg = GLYPH_8;
            4'h9:    seg = GLYPH_9;
            4'hA:    seg = GLYPH_A;
            4'hB:    seg = GLYPH_B;
            4'hC:    seg = GLYPH_C;
            4'hD:    seg = GLYPH_D;
            4'hE:    seg = GLYPH_E;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed display scanner with a double-buffered message register.
// New messages land in a pending slot and only become visible at a frame
// boundary, so a frame never shows a mix of old and new digits.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] msg_data,
    input  logic                          msg_valid,
    input  logic                          msg_blink,
    output logic                          msg_ready,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic [6:0]                    seg,
    output logic                          frame_tick
);

    generate
        if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || REFRESH_DIV < 2 || BLINK_DIV < 1) begin : g_param_err
            $error("disp_scan_ctrl: illegal parameters NUM_DIGITS=%0d REFRESH_DIV=%0d BLINK_DIV=%0d",
                   NUM_DIGITS, REFRESH_DIV, BLINK_DIV);
        end
    endgenerate

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

    typedef struct packed {
        logic                                blink;
        logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digits;
    } msg_t;

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [BW-1:0] bcnt;
    logic          bphase;
    logic          pend_full;
    msg_t          pend;
    msg_t          act;

    logic          term;
    logic          commit;
    logic          load;
    digit_t        cur_code;

    assign term       = (presc == PRE_LAST);
    assign frame_tick = term && (idx == IDX_LAST);
    assign msg_ready  = ~pend_full;
    assign load       = msg_valid && ~pend_full;
    // commit wins over load; they can never coincide since load needs an empty slot
    assign commit     = frame_tick && pend_full;

    // refresh prescaler and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (term) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // pending/active message buffers, committed only at frame end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_full   <= 1'b0;
            pend.blink  <= 1'b0;
            pend.digits <= {NUM_DIGITS{BLANK_CODE}};
            act.blink   <= 1'b0;
            act.digits  <= {NUM_DIGITS{BLANK_CODE}};
        end else if (commit) begin
            act       <= pend;
            pend_full <= 1'b0;
        end else if (load) begin
            pend.digits <= msg_data;
            pend.blink  <= msg_blink;
            pend_full   <= 1'b1;
        end
    end

    // blink frame counter; a fresh message always starts in the visible phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt   <= '0;
            bphase <= 1'b0;
        end else if (commit) begin
            bcnt   <= '0;
            bphase <= 1'b0;
        end else if (frame_tick) begin
            if (bcnt == BLK_LAST) begin
                bcnt   <= '0;
                bphase <= ~bphase;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    // active-low one-hot anode drive, all off during the dark blink phase
    always_comb begin
        digit_sel = '1;
        if (!(act.blink && bphase))
            digit_sel[idx] = 1'b0;
    end

    assign cur_code = act.digits[idx];

    seg7_decode u_dec (
        .code (cur_code),
        .seg  (seg)
    );

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of 4-bit display digits; legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles each digit stays enabled; legal value >= 2.
REQ-003 Parameter BLINK_DIV, default 16: frames per blink half-period; legal value >= 1.
REQ-004 clk  in  1  single system clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 msg_data  in  NUM_DIGITS*4  message word; digit 0 in bits [3:0]; code 4'hF means blank.
REQ-007 msg_valid  in  1  request to load msg_data and msg_blink.
REQ-008 msg_blink  in  1  blink attribute of the offered message.
REQ-009 msg_ready  out  1  high when a message can be accepted.
REQ-010 digit_sel  out  NUM_DIGITS  one-hot, active-low digit anode enables.
REQ-011 seg  out  7  active-low segments, order {g,f,e,d,c,b,a}.
REQ-012 frame_tick  out  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-013 A load SHALL be accepted only in a cycle with msg_valid=1 and msg_ready=1; it copies msg_data and msg_blink into the pending register and sets pending_full.
REQ-014 msg_ready SHALL equal the inverse of pending_full.
REQ-015 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; at the terminal count, digit index SHALL advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-016 frame_tick SHALL be 1 exactly in the cycle where the prescaler is at its terminal count and the index is NUM_DIGITS-1.
REQ-017 In a frame_tick cycle with pending_full=1, the pending message SHALL commit to the active register and pending_full SHALL clear, so that message changes never tear mid-frame.
REQ-018 If msg_valid arrives in a frame_tick cycle with pending_full=0, the message SHALL be accepted into pending and commit at the next frame_tick, not the current one.
REQ-019 If msg_valid arrives in a frame_tick cycle with pending_full=1, the existing pending message SHALL commit, the new one SHALL NOT be accepted, and msg_ready SHALL rise in the next cycle.
REQ-020 The blink frame counter SHALL count frame_ticks modulo BLINK_DIV and toggle blink_phase on wrap; both SHALL clear to 0 on every commit.
REQ-021 digit_sel SHALL be ~(1<<index), except all ones when the active blink attribute is 1 and blink_phase is 1.
REQ-022 seg SHALL be the combinational decode of active digit[index]: codes 0..E give hex glyphs 0-9 and A-E; code F gives 7'h7F (all segments off).
REQ-023 digit_sel and seg SHALL be combinational functions of registered state only, with no path from any input.

Reset
REQ-024 While reset=1: prescaler=0, index=0, pending_full=0, blink counter=0, blink_phase=0, and all active and pending digits = 4'hF.
REQ-025 Resulting outputs under reset SHALL be: msg_ready=1, frame_tick=0, digit_sel=~1, seg=7'h7F.
REQ-026 Reset asserted mid-frame or with a pending message SHALL discard both messages with no commit.

Structure
REQ-027 Shared package disp_pkg SHALL hold DIGIT_W=4, BLANK_CODE=4'hF, SEG_OFF=7'h7F, and the glyph constants.
REQ-028 The segment decode SHALL be a sub-module named seg7_decode (combinational, 4 bits in, 7 bits out).
REQ-029 Illegal parameter values SHALL be rejected by an elaboration-time check.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2)
REQ-030 Reset, then idle -> seg=7'h7F, msg_ready=1, digit_sel=4'b1110, and frame_tick every 16 cycles.
REQ-031 Load 16'h1A2F with blink=0 -> commit at the next frame_tick; then digit 0 is blank for 4 cycles, digit 1 shows "2", digit 2 shows "A", digit 3 shows "1".
REQ-032 Two back-to-back loads -> msg_ready is low after the first load until the cycle after frame_tick; the second message commits one frame later.
REQ-033 Load with blink=1 -> anodes active for frames 0-1 after commit, digit_sel=4'b1111 for frames 2-3, and the pattern repeats.
REQ-034 Pulse msg_valid coincident with frame_tick -> commit occurs at the following frame_tick, 16 cycles later.
REQ-035 Assert reset mid-frame with a pending message -> all outputs return to reset values, and no commit occurs after reset release.
